delay_sched: RTL
================

Name: delay_sched

Overview:
- Round-robin scheduler that shares one programmable delay timer between NREQ requesters.
- Each requester asks for a delay of N clock cycles. The block grants the timer to one requester at a time, counts out the delay, then returns a one-cycle completion pulse to that requester.
- Sits between the control logic of the timing-sensitive paths and the single shared delay resource. It replaces per-path delay elements with one sequenced, synthesizable timer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, width of each delay value in cycles.
- IW, 2, width of the granted-requester index; must be at least clog2(NREQ).

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  level request per requester; held high until done or abort.
- dly  input  NREQ*DW  packed delay values; requester i uses bits [i*DW +: DW].
- gnt  output  NREQ  one-hot grant; high while requester owns the timer.
- done  output  NREQ  one-hot, one-cycle completion pulse.
- busy  output  1  high whenever state is not IDLE.
- cur_id  output  IW  index of the granted requester; 0 when idle.
- remain  output  DW  current timer count; 0 when idle.

Behaviour:
- Reset (rst high at a rising edge):
  - state=IDLE, gnt=0, done=0, busy=0, cur_id=0, remain=0.
  - Round-robin pointer ptr=0.
  - Reset wins over every other event in any state, including mid-count; no done pulse is issued for the aborted transfer.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req!=0, select the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - Next edge: latch remain=dly[sel], cur_id=sel, gnt=onehot(sel), ptr=(sel+1) mod NREQ, state=COUNT.
  - If req=0, stay in IDLE.
- COUNT:
  - Each edge with req[cur_id] high: if remain==0, go to DONE; else remain=remain-1.
  - Result: gnt is high for exactly dly+1 cycles. dly=0 gives a 1-cycle grant.
  - Abort: req[cur_id] low at an edge in COUNT causes gnt=0, remain=0, cur_id=0 and a return to IDLE. No done pulse is issued and ptr is not rolled back.
  - The abort check takes priority over the remain==0 check.
  - Requests from other requesters are ignored (no preemption). dly changes after the grant are ignored, since the value was latched.
- DONE:
  - One cycle with done[cur_id]=1, gnt=0, busy=1, remain=0.
  - Next edge: done=0, cur_id=0, state=IDLE.
- Arbitration timing: a new grant is possible at the edge after DONE, so back-to-back transfers have a 2-cycle gap (DONE plus IDLE).
- Requester release: a requester should drop req in its DONE cycle. If it keeps req high, it re-enters arbitration in IDLE behind the other active requesters, because ptr has already advanced.
- Simultaneous requests: the lowest index at or after ptr wins. With ptr=0, req=4'b1010 grants requester 1.
- Wrap-around: ptr=NREQ-1 followed by a grant wraps ptr to 0.
- Invariants:
  - gnt and done are never both nonzero.
  - gnt and done each have at most one bit set.
  - remain never underflows.

Test Plan:
- Reset, then req=4'b0001, dly0=3 -> gnt=4'b0001 for 4 cycles with remain 3,2,1,0; then done=4'b0001 for 1 cycle; busy falls one cycle after done.
- req=4'b0100, dly2=0 -> gnt[2] high 1 cycle, then done[2] pulse; cur_id=2 while granted.
- req=4'b1111 held, all dly=1, each requester drops req in its done cycle and re-raises it the next cycle -> grants in order 0,1,2,3,0 with ptr wrapping; no requester is starved.
- Grant requester 1 with dly1=10, drop req[1] after 4 cycles in COUNT -> gnt drops next edge, no done pulse; the next grant goes to requester 2 if pending.
- Assert rst while in COUNT with remain=5 -> all outputs 0 at the next edge, no done pulse; a subsequent req=4'b0001 is granted to requester 0 (ptr=0).
- dly1=255 (maximum value) -> gnt[1] high 256 cycles, then done[1]; remain shows no underflow or wrap.

Source files
------------

// File: rtl/delay_sched.sv
`default_nettype none
// ============================================================================
// Module   : delay_sched
// Purpose  : Round-robin scheduler sharing one programmable delay timer
//            between NREQ requesters. The winner's delay value is latched, the
//            grant is held for dly+1 cycles, and then a one-cycle done pulse
//            returns to that requester. Dropping the request mid-count aborts
//            the transfer without a done pulse.
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous active-high reset
//            req    - level request per requester
//            dly    - packed delay values, requester i at [i*DW +: DW]
//            gnt    - one-hot grant, high while the requester owns the timer
//            done   - one-hot single-cycle completion pulse
//            busy   - high whenever the scheduler is not idle
//            cur_id - index of the granted requester, 0 when idle
//            remain - current timer count, 0 when idle
// Revision : 1.0 - initial release
// ============================================================================
module delay_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] dly,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [IW-1:0]     cur_id,
  output logic [DW-1:0]     remain
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [DW-1:0]   remain_q, remain_d;
  logic [IW-1:0]   cur_id_q, cur_id_d;
  logic [IW-1:0]   ptr_q,    ptr_d;

  logic [DW-1:0]   dly_arr [NREQ];
  logic            any_req;
  logic            hi_found;
  logic [IW-1:0]   hi_sel;
  logic [IW-1:0]   lo_sel;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   ptr_next;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dly_arr[i] = dly[i*DW +: DW];
    end
  end

  // Round-robin pick without a rotator: the lowest set bit at or above ptr
  // wins; if none exists the search has wrapped, so the lowest set bit
  // overall wins. Scanning downward lets the last hit be the lowest index.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        lo_sel  = IW'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_sel   = IW'(i);
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  assign ptr_next = (int'(sel) == NREQ - 1) ? '0 : sel + IW'(1);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    cur_id_d = cur_id_q;
    ptr_d    = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d  = S_COUNT;
          remain_d = dly_arr[sel];
          cur_id_d = sel;
          ptr_d    = ptr_next;
        end
      end
      S_COUNT: begin
        // Abort outranks expiry; ptr has already moved past the owner.
        if (!req[cur_id_q]) begin
          state_d  = S_IDLE;
          remain_d = '0;
          cur_id_d = '0;
        end else if (remain_q == '0) begin
          state_d = S_DONE;
        end else begin
          remain_d = remain_q - DW'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        cur_id_d = '0;
      end
      default: begin
        state_d  = S_IDLE;
        remain_d = '0;
        cur_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      cur_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      cur_id_q <= cur_id_d;
      ptr_q    <= ptr_d;
    end
  end

  // Grant and done both decode cur_id; the state gates which one is live,
  // so they can never be asserted together.
  always_comb begin
    gnt  = '0;
    done = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i]  = (state_q == S_COUNT) && (cur_id_q == IW'(i));
      done[i] = (state_q == S_DONE)  && (cur_id_q == IW'(i));
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign cur_id = cur_id_q;
  assign remain = remain_q;

endmodule
`default_nettype wire
